// File: rtl/accel_ctrl_if.sv
// ============================================================================
// Module  : accel_ctrl_if
// Brief   : Start/finish handshake and single-port pixel memory bus of the
//           task3 image accelerator sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface accel_ctrl_if;
    logic        start;
    logic        finish;
    logic        en;
    logic        we;
    logic [15:0] addr;
    logic [31:0] dataW;
    logic [31:0] dataR;

    // master: the sequencer; slave: the memory / host side
    modport master (
        input  start,
        input  dataR,
        output finish,
        output en,
        output we,
        output addr,
        output dataW
    );

    modport slave (
        output start,
        output dataR,
        input  finish,
        input  en,
        input  we,
        input  addr,
        input  dataW
    );
endinterface

`default_nettype wire

// File: rtl/accel_ctrl.sv
// ============================================================================
// Module  : accel_ctrl
// Brief   : Streams IMG_WORDS words through a per-byte pixel transform,
//           read from 0..IMG_WORDS-1, written to OUT_BASE+i (2 cycles/word).
//           Optional macro ACCEL_THRESHOLD_EN selects binarisation instead
//           of pixel inversion.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module accel_ctrl #(
    parameter int unsigned IMG_WORDS = 25344,
    parameter int unsigned OUT_BASE  = 25344,
    parameter int unsigned THRESHOLD = 128
) (
    input  wire logic     clk,
    input  wire logic     reset,
    accel_ctrl_if.master  bus
);

    localparam logic [15:0] C_LAST     = 16'(IMG_WORDS - 1);
    localparam logic [15:0] C_OUT_BASE = 16'(OUT_BASE);

    generate
        if ((IMG_WORDS == 0) || (IMG_WORDS + OUT_BASE > 65536)) begin : g_bad_addr_range
            $error("accel_ctrl: IMG_WORDS/OUT_BASE do not fit the 16-bit address space");
        end
        if (THRESHOLD > 255) begin : g_bad_threshold
            $error("accel_ctrl: THRESHOLD must fit in one byte");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        en_q, en_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic        finish_q, finish_d;

`ifdef ACCEL_THRESHOLD_EN
    localparam logic [7:0] C_THRESHOLD = 8'(THRESHOLD);

    function automatic logic [7:0] pix_f(input logic [7:0] b);
        pix_f = (b >= C_THRESHOLD) ? 8'hFF : 8'h00;
    endfunction
`else
    function automatic logic [7:0] pix_f(input logic [7:0] b);
        pix_f = 8'hFF - b;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_READ;
                    cnt_d   = 16'd0;
                end
            end
            S_READ: state_d = S_WRITE;
            S_WRITE: begin
                if (cnt_q == C_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_READ;
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                if (!bus.start) begin
                    state_d = S_IDLE;
                    cnt_d   = 16'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they come straight from flops
    always_comb begin
        en_d     = (state_d == S_READ) || (state_d == S_WRITE);
        we_d     = (state_d == S_WRITE);
        finish_d = (state_d == S_DONE);
        case (state_d)
            S_READ:  addr_d = cnt_d;
            S_WRITE: addr_d = cnt_d + C_OUT_BASE;
            default: addr_d = 16'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 16'd0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            finish_q <= finish_d;
        end
    end

    // Read data arrives the cycle after READ, so the transform is combinational
    always_comb begin
        bus.dataW = 32'd0;
        if (state_q == S_WRITE) begin
            for (int j = 0; j < 4; j++) begin
                bus.dataW[8*j +: 8] = pix_f(bus.dataR[8*j +: 8]);
            end
        end
    end

    assign bus.en     = en_q;
    assign bus.we     = we_q;
    assign bus.addr   = addr_q;
    assign bus.finish = finish_q;

endmodule

`default_nettype wire

// File: tb/tb_accel_ctrl.sv
// ============================================================================
// Module  : tb_accel_ctrl
// Brief   : Directed bench: a 4-word instance with a small RAM model and a
//           full-size default instance processing a whole frame.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_accel_ctrl;

    localparam int C_SMALL_WORDS = 4;
    localparam int C_SMALL_BASE  = 4;
    localparam int C_FULL_WORDS  = 25344;
    localparam int C_FULL_BASE   = 25344;
    localparam logic [31:0] C_SENTINEL = 32'hDEADBEEF;

    logic clk;
    logic reset;
    logic reset_f;

    int checks = 0;
    int errors = 0;

    accel_ctrl_if bus ();
    accel_ctrl_if bus_f ();

    accel_ctrl #(
        .IMG_WORDS (C_SMALL_WORDS),
        .OUT_BASE  (C_SMALL_BASE),
        .THRESHOLD (128)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    accel_ctrl dut_f (
        .clk   (clk),
        .reset (reset_f),
        .bus   (bus_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_word(input logic [31:0] w);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) begin
`ifdef ACCEL_THRESHOLD_EN
            r[8*j +: 8] = (w[8*j +: 8] >= 8'd128) ? 8'hFF : 8'h00;
`else
            r[8*j +: 8] = 8'hFF - w[8*j +: 8];
`endif
        end
        return r;
    endfunction

    // Hand-computed results for the four small input words
    logic [31:0] small_in  [0:3];
    logic [31:0] small_exp [0:3];
    initial begin
        small_in[0] = 32'h00FF7F80;
        small_in[1] = 32'h12345678;
        small_in[2] = 32'hA5A5A5A5;
        small_in[3] = 32'hFFFFFFFF;
`ifdef ACCEL_THRESHOLD_EN
        small_exp[0] = 32'h00FF00FF;
        small_exp[1] = 32'h00000000;
        small_exp[2] = 32'hFFFFFFFF;
        small_exp[3] = 32'hFFFFFFFF;
`else
        small_exp[0] = 32'hFF00807F;
        small_exp[1] = 32'hEDCBA987;
        small_exp[2] = 32'h5A5A5A5A;
        small_exp[3] = 32'h00000000;
`endif
    end

    // Registered read-first single-port RAMs; contents loaded on the first edge
    logic [31:0] mem   [0:7];
    int          wcnt  [0:7];
    logic [31:0] mem_f [0:C_FULL_WORDS+C_FULL_BASE-1];
    bit          init_done = 1'b0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 4; i++) begin
                mem[i]     <= small_in[i];
                mem[i + 4] <= C_SENTINEL;
            end
            for (int i = 0; i < 8; i++) wcnt[i] <= 0;
            for (int i = 0; i < C_FULL_WORDS; i++) begin
                mem_f[i]               <= 32'(i) * 32'h9E3779B1 ^ 32'h00FF7F80;
                mem_f[C_FULL_BASE + i] <= 32'd0;
            end
            init_done <= 1'b1;
        end else begin
            if (bus.en && bus.addr < 16'd8) begin
                bus.dataR <= mem[bus.addr[2:0]];
                if (bus.we) begin
                    mem[bus.addr[2:0]]  <= bus.dataW;
                    wcnt[bus.addr[2:0]] <= wcnt[bus.addr[2:0]] + 1;
                end
            end
            if (bus_f.en && int'(bus_f.addr) < C_FULL_WORDS + C_FULL_BASE) begin
                bus_f.dataR <= mem_f[bus_f.addr];
                if (bus_f.we) mem_f[bus_f.addr] <= bus_f.dataW;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n;
    int base [0:7];
    int bad;

    initial begin
        reset       = 1'b1;
        reset_f     = 1'b1;
        bus.start   = 1'b1;
        bus_f.start = 1'b0;
        repeat (3) tick();
        check("rst_en",     32'(bus.en),     32'd0);
        check("rst_we",     32'(bus.we),     32'd0);
        check("rst_addr",   32'(bus.addr),   32'd0);
        check("rst_dataW",  bus.dataW,       32'd0);
        check("rst_finish", 32'(bus.finish), 32'd0);

        // Run 1: start held through reset release, toggled during WRITE of word 2
        reset = 1'b0;
        tick();
        check("rd0_en",   32'(bus.en),   32'd1);
        check("rd0_we",   32'(bus.we),   32'd0);
        check("rd0_addr", 32'(bus.addr), 32'd0);
        n = 0;
        while (!bus.finish && n < 40) begin
            tick();
            n++;
            if (n == 1) check("wr0_dataW", bus.dataW, small_exp[0]);
            if (n == 5) begin
                check("wr2_we",   32'(bus.we),   32'd1);
                check("wr2_addr", 32'(bus.addr), 32'd6);
                bus.start = 1'b0;
            end
            if (n == 6) bus.start = 1'b1;
        end
        check("run1_finish_latency", 32'(n), 32'd8);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("run1_mem%0d", i + 4), mem[i + 4], small_exp[i]);
            check($sformatf("run1_wcnt%0d", i + 4), 32'(wcnt[i + 4]), 32'd1);
            check($sformatf("run1_in%0d", i), mem[i], small_in[i]);
        end
        repeat (3) tick();
        check("done_hold_finish", 32'(bus.finish), 32'd1);
        check("done_hold_en",     32'(bus.en),     32'd0);
        check("done_hold_addr",   32'(bus.addr),   32'd0);
        bus.start = 1'b0;
        tick();
        check("finish_fall", 32'(bus.finish), 32'd0);

        // Run 2: reset during READ of word 2, then restart from word 0
        for (int i = 0; i < 8; i++) base[i] = wcnt[i];
        bus.start = 1'b1;
        tick();
        check("run2_rd0_addr", 32'(bus.addr), 32'd0);
        bus.start = 1'b0;
        repeat (4) tick();
        check("run2_rd2_en",   32'(bus.en),   32'd1);
        check("run2_rd2_we",   32'(bus.we),   32'd0);
        check("run2_rd2_addr", 32'(bus.addr), 32'd2);
        reset = 1'b1;
        tick();
        check("midrst_en", 32'(bus.en), 32'd0);
        check("midrst_we", 32'(bus.we), 32'd0);
        reset = 1'b0;
        tick();
        check("postrst_en",  32'(bus.en), 32'd0);
        check("partial_w4",  32'(wcnt[4] - base[4]), 32'd1);
        check("partial_w5",  32'(wcnt[5] - base[5]), 32'd1);
        check("partial_no6", 32'(wcnt[6] - base[6]), 32'd0);
        bus.start = 1'b1;
        tick();
        check("rerun_addr", 32'(bus.addr), 32'd0);
        check("rerun_en",   32'(bus.en),   32'd1);
        n = 0;
        while (!bus.finish && n < 40) begin
            tick();
            n++;
        end
        check("run2_finish_latency", 32'(n), 32'd8);
        for (int i = 0; i < 4; i++)
            check($sformatf("run2_mem%0d", i + 4), mem[i + 4], small_exp[i]);
        check("run2_w4_total", 32'(wcnt[4] - base[4]), 32'd2);
        check("run2_w6_total", 32'(wcnt[6] - base[6]), 32'd1);
        bus.start = 1'b0;
        tick();

        // Full frame with default parameters, start held until finish
        reset_f = 1'b0;
        tick();
        bus_f.start = 1'b1;
        tick();
        check("full_rd0_en", 32'(bus_f.en), 32'd1);
        n = 0;
        while (!bus_f.finish && n < 60000) begin
            tick();
            n++;
        end
        check("full_finish_latency", 32'(n), 32'd50688);
        tick();
        bad = 0;
        for (int i = 0; i < C_FULL_WORDS; i++)
            if (mem_f[C_FULL_BASE + i] !== exp_word(mem_f[i])) bad++;
        check("full_image_bad_words", 32'(bad), 32'd0);
        check("full_word0", mem_f[C_FULL_BASE], exp_word(mem_f[0]));
        check("full_word_last", mem_f[C_FULL_BASE + C_FULL_WORDS - 1],
              exp_word(mem_f[C_FULL_WORDS - 1]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
